// File: rtl/param_seq_detector.sv
// Serial pattern detector with a run-time loadable pattern and length, optional
// overlapping matches, and a saturating match counter.
module param_seq_detector #(
    parameter int                 PAT_W   = 8,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_W-1:0]   DEF_PAT = PAT_W'(8'b0000_0110),
    parameter int                 DEF_LEN = 4,
    localparam int                LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] match_count
);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic [PAT_W-1:0] mask;
    logic             hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : l;
    endfunction

    always_comb begin
        hist_next = {hist[PAT_W-2:0], x};
        fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
        mask      = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        // Only the newest len bits take part; fill guards against matching reset zeros.
        hit = in_valid && !cfg_load && (len != '0) && (fill_next >= len) &&
              (((hist_next ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            pattern     <= DEF_PAT;
            len         <= LEN_W'(DEF_LEN);
            z           <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= clamp_len(cfg_len);
                hist    <= '0;
                fill    <= '0;
                z       <= 1'b0;
            end else if (in_valid) begin
                hist <= hist_next;
                fill <= (hit && !overlap) ? '0 : fill_next;
                z    <= hit;
            end else begin
                z <= 1'b0;
            end

            if (cnt_clr) begin
                match_count <= hit ? CNT_W'(1) : '0;
            end else if (hit) begin
                match_count <= sat_inc(match_count);
            end
        end
    end

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: directed scenarios plus random traffic, checked
// against a queue-based model of the accepted bit stream.
module tb_param_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cnt_clr = 1'b0;
    logic       z, z2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int checks = 0;
    int failures = 0;

    param_seq_detector dut (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .z(z), .match_count(match_count)
    );

    param_seq_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .z(z2), .match_count(match_count2)
    );

    always #5 clk = ~clk;

    // Model: the accepted bits since the last clear, capped at the 8 most recent.
    bit       q[$];
    bit [7:0] mpat;
    int       mlen;
    bit       mz;
    int       c8, c2;
    bit       ov_cur;

    task automatic model_reset();
        q.delete();
        mpat = 8'b0000_0110;
        mlen = 4;
        mz   = 0;
        c8   = 0;
        c2   = 0;
    endtask

    task automatic model_edge();
        bit hit;
        hit = 0;
        if (cfg_load) begin
            mpat = cfg_pattern;
            mlen = (cfg_len > 8) ? 8 : int'(cfg_len);
            q.delete();
        end else if (in_valid) begin
            q.push_back(x);
            if (q.size() > 8) void'(q.pop_front());
            if (mlen > 0 && q.size() >= mlen) begin
                hit = 1;
                for (int i = 0; i < mlen; i++)
                    if (q[q.size() - 1 - i] != mpat[i]) hit = 0;
            end
            if (hit && !overlap) q.delete();
        end
        mz = hit;
        if (cnt_clr) begin
            c8 = hit ? 1 : 0;
            c2 = hit ? 1 : 0;
        end else if (hit) begin
            c8 = (c8 == 255) ? 255 : c8 + 1;
            c2 = (c2 == 3) ? 3 : c2 + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_z"}, 32'(z), 32'(mz));
        chk({tag, "_z2"}, 32'(z2), 32'(mz));
        chk({tag, "_cnt"}, 32'(match_count), 32'(c8));
        chk({tag, "_cnt2"}, 32'(match_count2), 32'(c2));
    endtask

    task automatic step(input logic xb, input logic v, input logic ld,
                        input logic [7:0] pat, input logic [3:0] ln,
                        input logic clr, input string tag);
        x = xb; in_valid = v; overlap = ov_cur; cfg_load = ld;
        cfg_pattern = pat; cfg_len = ln; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic bit_in(input logic b, input string tag);
        step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, tag);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln);
        step(1'b1, 1'b1, 1'b1, pat, ln, 1'b1, "load");
    endtask

    // Reset asserted between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rp;
        logic       t1 [12] = '{0,1,1,0,0,0,0,0,0,1,1,0};
        logic       t2 [6]  = '{1,0,1,0,1,0};
        int         t4exp [6] = '{1,2,3,3,3,3};

        model_reset();
        ov_cur = 0;
        #1;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: default pattern 0110, non-overlapping
        foreach (t1[i]) bit_in(t1[i], "t1");
        chk("t1_count", 32'(match_count), 32'd2);

        // T2: 1010 overlapping then non-overlapping
        ov_cur = 1;
        load(8'b0000_1010, 4'd4);
        foreach (t2[i]) bit_in(t2[i], "t2ov");
        chk("t2_ov_count", 32'(match_count), 32'd2);
        ov_cur = 0;
        load(8'b0000_1010, 4'd4);
        foreach (t2[i]) bit_in(t2[i], "t2nov");
        chk("t2_nov_count", 32'(match_count), 32'd1);

        // T3: gaps inside a partial match
        load(8'b0000_0110, 4'd4);
        bit_in(0, "t3"); bit_in(1, "t3"); bit_in(1, "t3");
        for (int i = 0; i < 3; i++)
            step(1'($urandom_range(1)), 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, "t3gap");
        bit_in(0, "t3");
        chk("t3_z", 32'(z), 32'd1);

        // T4: saturation of the 2-bit counter, then clear with a coincident match
        ov_cur = 1;
        load(8'b0000_0001, 4'd1);
        for (int i = 0; i < 6; i++) begin
            bit_in(1, "t4");
            chk("t4_seq", 32'(match_count2), 32'(t4exp[i]));
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, "t4clr");
        chk("t4_clr_match", 32'(match_count2), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, "t4clr0");
        chk("t4_clr_only", 32'(match_count), 32'd0);

        // T5: len 0 disables, oversized len clamps to 8
        load(8'h00, 4'd0);
        for (int i = 0; i < 20; i++) bit_in(1'($urandom_range(1)), "t5off");
        chk("t5_off_count", 32'(match_count), 32'd0);
        rp = 8'($urandom);
        load(rp, 4'd11);
        for (int i = 7; i >= 0; i--) bit_in(rp[i], "t5full");
        chk("t5_full_z", 32'(z), 32'd1);

        // T6: reset mid-match loses the partial match
        ov_cur = 0;
        load(8'b0000_0110, 4'd4);
        bit_in(0, "t6"); bit_in(1, "t6"); bit_in(1, "t6");
        async_reset("t6rst");
        bit_in(0, "t6post");
        chk("t6_nomatch", 32'(z), 32'd0);
        bit_in(0, "t6b"); bit_in(1, "t6b"); bit_in(1, "t6b"); bit_in(0, "t6b");
        chk("t6_match", 32'(z), 32'd1);

        // Random traffic with short patterns so matches are frequent
        for (int i = 0; i < 600; i++) begin
            ov_cur = 1'($urandom_range(1));
            if ($urandom_range(40) == 0)
                step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 8'($urandom),
                     4'($urandom_range(4)), 1'($urandom_range(1)), "rnd_ld");
            else
                step(1'($urandom_range(1)), 1'($urandom_range(3) != 0), 1'b0, 8'h00,
                     4'd0, 1'($urandom_range(50) == 0), "rnd");
            if (i == 300) async_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
